// File: rtl/pa_dcache_data_ctrl_pkg.sv
// Shared LSU definitions for the dcache data-array controller: FSM states,
// default geometry and the idle (inactive) levels of the active-low SRAM pins.
package pa_dcache_data_ctrl_pkg;

  localparam int DC_IDX_WIDTH  = 12;
  localparam int DC_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RFL  = 2'd1,
    ST_WB   = 2'd2
  } data_state_e;

  localparam logic        SRAM_CEN_IDLE  = 1'b1;
  localparam logic        SRAM_GWEN_IDLE = 1'b1;
  localparam logic [31:0] SRAM_WEN_IDLE  = 32'hFFFF_FFFF;

  localparam logic RD_OWNER_LD = 1'b0;
  localparam logic RD_OWNER_WB = 1'b1;

  // Byte enables (active-high) to SRAM bit write enables (active-low).
  function automatic logic [31:0] be_to_wen(input logic [3:0] be);
    logic [31:0] wen;
    for (int k = 0; k < 4; k++) begin
      wen[8*k +: 8] = {8{~be[k]}};
    end
    return wen;
  endfunction

endpackage

// File: rtl/pa_dcache_data_arb.sv
// Single-grant priority arbiter for the data array (rfl > wb > st > ld) with a
// saturating counter that promotes a load above stores after repeated losses.
module pa_dcache_data_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic rfl_req,
  input  logic wb_req,
  input  logic st_req,
  input  logic ld_req,
  output logic gnt_rfl,
  output logic gnt_wb,
  output logic gnt_st,
  output logic gnt_ld
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          ld_promote;

  assign ld_promote = (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    gnt_rfl = 1'b0;
    gnt_wb  = 1'b0;
    gnt_st  = 1'b0;
    gnt_ld  = 1'b0;
    if (arb_en) begin
      if (rfl_req)                              gnt_rfl = 1'b1;
      else if (wb_req)                          gnt_wb  = 1'b1;
      else if (ld_req && (ld_promote || !st_req)) gnt_ld = 1'b1;
      else if (st_req)                          gnt_st  = 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!ld_req || gnt_ld)          starve_d = '0;
    else if (gnt_st && !ld_promote) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

endmodule

// File: rtl/pa_dcache_data_ctrl.sv
// Data-array sequencer: arbitrates refill/write-back bursts and single store/load
// accesses onto the single-port SRAM and steers read data back to its owner.
module pa_dcache_data_ctrl
  import pa_dcache_data_ctrl_pkg::*;
#(
  parameter int IDX_WIDTH    = DC_IDX_WIDTH,
  parameter int LINE_WORDS   = DC_LINE_WORDS,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic                 ld_req,
  input  logic [IDX_WIDTH-1:0] ld_idx,
  output logic                 ld_gnt,
  output logic                 ld_data_vld,
  output logic [31:0]          ld_data,
  input  logic                 st_req,
  input  logic [IDX_WIDTH-1:0] st_idx,
  input  logic [3:0]           st_be,
  input  logic [31:0]          st_data,
  output logic                 st_gnt,
  input  logic                 rfl_req,
  input  logic [IDX_WIDTH-1:0] rfl_idx,
  input  logic                 rfl_data_vld,
  input  logic [31:0]          rfl_data,
  output logic                 rfl_gnt,
  output logic                 rfl_done,
  input  logic                 wb_req,
  input  logic [IDX_WIDTH-1:0] wb_idx,
  output logic                 wb_gnt,
  output logic                 wb_data_vld,
  output logic [31:0]          wb_data,
  output logic                 wb_done,
  input  logic [31:0]          data_dout,
  output logic                 data_clk_en,
  output logic                 data_cen,
  output logic                 data_gwen,
  output logic [31:0]          data_wen,
  output logic [31:0]          data_din,
  output logic [IDX_WIDTH-1:0] data_idx
);

  localparam int LWB = $clog2(LINE_WORDS);
  localparam int BW  = IDX_WIDTH - LWB;

  data_state_e    state_q, state_d;
  logic [LWB-1:0] cnt_q, cnt_d;
  logic [BW-1:0]  base_q, base_d;
  logic           rd_vld_q, rd_vld_d;
  logic           rd_owner_q, rd_owner_d;
  logic           rd_last_q, rd_last_d;
  logic           gnt_rfl, gnt_wb, gnt_st, gnt_ld;
  logic           unused_idx_lsb;

  assign unused_idx_lsb = ^{rfl_idx[LWB-1:0], wb_idx[LWB-1:0]};

  pa_dcache_data_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk     (forever_cpuclk),
    .rst     (cpurst),
    .arb_en  ((state_q == ST_IDLE) && !cpurst),
    .rfl_req (rfl_req),
    .wb_req  (wb_req),
    .st_req  (st_req),
    .ld_req  (ld_req),
    .gnt_rfl (gnt_rfl),
    .gnt_wb  (gnt_wb),
    .gnt_st  (gnt_st),
    .gnt_ld  (gnt_ld)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    rd_vld_d   = 1'b0;
    rd_owner_d = RD_OWNER_LD;
    rd_last_d  = 1'b0;
    data_cen   = SRAM_CEN_IDLE;
    data_gwen  = SRAM_GWEN_IDLE;
    data_wen   = SRAM_WEN_IDLE;
    data_din   = '0;
    data_idx   = '0;
    ld_gnt     = 1'b0;
    st_gnt     = 1'b0;
    rfl_gnt    = 1'b0;
    wb_gnt     = 1'b0;
    rfl_done   = 1'b0;
    if (!cpurst) begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_rfl) begin
            rfl_gnt = 1'b1;
            base_d  = rfl_idx[IDX_WIDTH-1:LWB];
            cnt_d   = '0;
            state_d = ST_RFL;
          end else if (gnt_wb) begin
            // Word 0 is read in the grant cycle so the burst is back-to-back.
            wb_gnt     = 1'b1;
            data_cen   = 1'b0;
            data_idx   = {wb_idx[IDX_WIDTH-1:LWB], {LWB{1'b0}}};
            rd_vld_d   = 1'b1;
            rd_owner_d = RD_OWNER_WB;
            base_d     = wb_idx[IDX_WIDTH-1:LWB];
            cnt_d      = LWB'(1);
            state_d    = ST_WB;
          end else if (gnt_st) begin
            st_gnt    = 1'b1;
            data_cen  = (st_be == 4'b0000);
            data_gwen = 1'b0;
            data_wen  = be_to_wen(st_be);
            data_din  = st_data;
            data_idx  = st_idx;
          end else if (gnt_ld) begin
            ld_gnt     = 1'b1;
            data_cen   = 1'b0;
            data_idx   = ld_idx;
            rd_vld_d   = 1'b1;
            rd_owner_d = RD_OWNER_LD;
          end
        end
        ST_RFL: begin
          if (rfl_data_vld) begin
            data_cen  = 1'b0;
            data_gwen = 1'b0;
            data_wen  = '0;
            data_din  = rfl_data;
            data_idx  = {base_q, cnt_q};
            cnt_d     = cnt_q + LWB'(1);
            if (cnt_q == LWB'(LINE_WORDS - 1)) begin
              rfl_done = 1'b1;
              state_d  = ST_IDLE;
            end
          end
        end
        ST_WB: begin
          data_cen   = 1'b0;
          data_idx   = {base_q, cnt_q};
          rd_vld_d   = 1'b1;
          rd_owner_d = RD_OWNER_WB;
          cnt_d      = cnt_q + LWB'(1);
          if (cnt_q == LWB'(LINE_WORDS - 1)) begin
            rd_last_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign data_clk_en = ~data_cen;
  assign ld_data_vld = rd_vld_q && (rd_owner_q == RD_OWNER_LD);
  assign wb_data_vld = rd_vld_q && (rd_owner_q == RD_OWNER_WB);
  assign wb_done     = wb_data_vld && rd_last_q;
  assign ld_data     = ld_data_vld ? data_dout : '0;
  assign wb_data     = wb_data_vld ? data_dout : '0;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      rd_vld_q   <= 1'b0;
      rd_owner_q <= RD_OWNER_LD;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      rd_vld_q   <= rd_vld_d;
      rd_owner_q <= rd_owner_d;
      rd_last_q  <= rd_last_d;
    end
  end

endmodule

// File: tb/tb_pa_dcache_data_ctrl.sv
// Bench for pa_dcache_data_ctrl: behavioural SRAM plus a word-level shadow memory
// that tracks what each transaction should leave in the array.
module tb_pa_dcache_data_ctrl;

  localparam int IW = 12;
  localparam int LW = 4;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          cpurst;
  logic          ld_req, ld_gnt, ld_data_vld;
  logic [IW-1:0] ld_idx;
  logic [31:0]   ld_data;
  logic          st_req, st_gnt;
  logic [IW-1:0] st_idx;
  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic          rfl_req, rfl_data_vld, rfl_gnt, rfl_done;
  logic [IW-1:0] rfl_idx;
  logic [31:0]   rfl_data;
  logic          wb_req, wb_gnt, wb_data_vld, wb_done;
  logic [IW-1:0] wb_idx;
  logic [31:0]   wb_data;
  logic [31:0]   data_dout;
  logic          data_clk_en, data_cen, data_gwen;
  logic [31:0]   data_wen, data_din;
  logic [IW-1:0] data_idx;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [0:4095];
  logic [31:0] sram    [0:4095];

  always #5 clk = ~clk;

  pa_dcache_data_ctrl #(.IDX_WIDTH(IW), .LINE_WORDS(LW), .STARVE_LIMIT(SL)) dut (
    .forever_cpuclk(clk), .cpurst(cpurst),
    .ld_req(ld_req), .ld_idx(ld_idx), .ld_gnt(ld_gnt), .ld_data_vld(ld_data_vld), .ld_data(ld_data),
    .st_req(st_req), .st_idx(st_idx), .st_be(st_be), .st_data(st_data), .st_gnt(st_gnt),
    .rfl_req(rfl_req), .rfl_idx(rfl_idx), .rfl_data_vld(rfl_data_vld), .rfl_data(rfl_data),
    .rfl_gnt(rfl_gnt), .rfl_done(rfl_done),
    .wb_req(wb_req), .wb_idx(wb_idx), .wb_gnt(wb_gnt), .wb_data_vld(wb_data_vld),
    .wb_data(wb_data), .wb_done(wb_done),
    .data_dout(data_dout), .data_clk_en(data_clk_en), .data_cen(data_cen), .data_gwen(data_gwen),
    .data_wen(data_wen), .data_din(data_din), .data_idx(data_idx)
  );

  function automatic logic [31:0] seed_word(input int i);
    return (i * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  // Memory after a store: each enabled byte takes the new data, others keep the old.
  function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // Single-port SRAM with 1-cycle read latency and active-low bit write enables.
  initial begin
    for (int i = 0; i < 4096; i++) sram[i] = seed_word(i);
    forever begin
      @(posedge clk);
      if (data_cen === 1'b0) begin
        if (data_gwen === 1'b0) sram[data_idx] = (sram[data_idx] & data_wen) | (data_din & ~data_wen);
        else                    data_dout <= sram[data_idx];
      end
    end
  end

  task automatic clear_inputs();
    ld_req = 0; st_req = 0; rfl_req = 0; wb_req = 0; rfl_data_vld = 0;
    ld_idx = '0; st_idx = '0; st_be = '0; st_data = '0; rfl_idx = '0; rfl_data = '0; wb_idx = '0;
  endtask

  task automatic do_load(input logic [IW-1:0] idx, output logic vld, output logic [31:0] d);
    @(negedge clk); ld_req = 1; ld_idx = idx;
    @(negedge clk); ld_req = 0; #1;
    vld = ld_data_vld; d = ld_data;
  endtask

  task automatic test_reset();
    @(negedge clk);
    cpurst = 1; ld_req = 1; st_req = 1; st_be = 4'hF; rfl_req = 1; wb_req = 1; rfl_data_vld = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if ({ld_gnt, st_gnt, rfl_gnt, wb_gnt} !== 4'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", {ld_gnt, st_gnt, rfl_gnt, wb_gnt}); end
      total++; if ({data_cen, data_gwen, data_clk_en} !== 3'b110) begin bad++; $display("FAIL reset_cen_gwen_clken got=%b exp=110", {data_cen, data_gwen, data_clk_en}); end
      total++; if (data_wen !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_wen got=%h exp=ffffffff", data_wen); end
      total++; if ({ld_data_vld, wb_data_vld, rfl_done, wb_done} !== 4'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0000", {ld_data_vld, wb_data_vld, rfl_done, wb_done}); end
      @(negedge clk);
    end
    cpurst = 0; clear_inputs(); #1;
    total++; if ({data_cen, data_clk_en} !== 2'b10) begin bad++; $display("FAIL idle_cen got=%b exp=10", {data_cen, data_clk_en}); end
  endtask

  task automatic test_load();
    @(negedge clk); ld_req = 1; ld_idx = 12'h010; #1;
    total++; if ({ld_gnt, data_cen, data_gwen, data_clk_en} !== 4'b1011) begin bad++; $display("FAIL ld_issue gnt/cen/gwen/clken got=%b exp=1011", {ld_gnt, data_cen, data_gwen, data_clk_en}); end
    total++; if (data_idx !== 12'h010) begin bad++; $display("FAIL ld_idx got=%h exp=010", data_idx); end
    @(negedge clk); ld_req = 0; #1;
    total++; if (ld_data_vld !== 1'b1 || ld_data !== ref_mem[12'h010]) begin bad++; $display("FAIL ld_data vld=%b got=%h exp=%h", ld_data_vld, ld_data, ref_mem[12'h010]); end
    total++; if (wb_data_vld !== 1'b0) begin bad++; $display("FAIL ld_owner wb_data_vld got=%b exp=0", wb_data_vld); end
  endtask

  task automatic test_store();
    logic vld;
    logic [31:0] d;
    logic [IW-1:0] ia;
    @(negedge clk); st_req = 1; st_idx = 12'h020; st_be = 4'b0101; st_data = 32'hAABB_CCDD; #1;
    total++; if ({st_gnt, data_cen, data_gwen} !== 3'b100) begin bad++; $display("FAIL st_issue gnt/cen/gwen got=%b exp=100", {st_gnt, data_cen, data_gwen}); end
    total++; if (data_wen !== 32'hFF00_FF00 || data_din !== 32'hAABB_CCDD || data_idx !== 12'h020) begin bad++; $display("FAIL st_bus wen=%h din=%h idx=%h exp ff00ff00 aabbccdd 020", data_wen, data_din, data_idx); end
    ref_mem[12'h020] = merge_store(ref_mem[12'h020], 32'hAABB_CCDD, 4'b0101);
    // Zero byte enables: granted but no access; stray refill beat valid is ignored in IDLE.
    ia = IW'($urandom);
    @(negedge clk); st_idx = ia; st_be = 4'b0000; st_data = $urandom; rfl_data_vld = 1; #1;
    total++; if ({st_gnt, data_cen, data_clk_en} !== 3'b110) begin bad++; $display("FAIL st_be0 gnt/cen/clken got=%b exp=110", {st_gnt, data_cen, data_clk_en}); end
    @(negedge clk); clear_inputs();
    do_load(12'h020, vld, d);
    total++; if (vld !== 1'b1 || d !== ref_mem[12'h020]) begin bad++; $display("FAIL st_readback vld=%b got=%h exp=%h", vld, d, ref_mem[12'h020]); end
    do_load(ia, vld, d);
    total++; if (vld !== 1'b1 || d !== ref_mem[ia]) begin bad++; $display("FAIL st_be0_readback vld=%b got=%h exp=%h", vld, d, ref_mem[ia]); end
  endtask

  task automatic test_refill();
    int pat [7] = '{1, 0, 1, 0, 0, 1, 1};
    int beat = 0;
    @(negedge clk); rfl_req = 1; rfl_idx = 12'h043; ld_req = 1; ld_idx = 12'h040; #1;
    total++; if ({rfl_gnt, ld_gnt, data_cen} !== 3'b101) begin bad++; $display("FAIL rfl_gnt gnt/ldgnt/cen got=%b exp=101", {rfl_gnt, ld_gnt, data_cen}); end
    for (int c = 0; c < 7; c++) begin
      @(negedge clk); rfl_req = 0; rfl_data_vld = pat[c][0]; rfl_data = $urandom; #1;
      total++; if (ld_gnt !== 1'b0 || rfl_gnt !== 1'b0) begin bad++; $display("FAIL rfl_stall c=%0d ld_gnt=%b rfl_gnt=%b exp 0 0", c, ld_gnt, rfl_gnt); end
      if (pat[c] != 0) begin
        total++;
        if ({data_cen, data_gwen} !== 2'b00 || data_wen !== 32'h0 || data_idx !== IW'(12'h040 + beat) || data_din !== rfl_data) begin
          bad++; $display("FAIL rfl_beat%0d cen=%b gwen=%b wen=%h idx=%h din=%h exp idx=%h din=%h", beat, data_cen, data_gwen, data_wen, data_idx, data_din, 12'h040 + beat, rfl_data);
        end
        total++; if (rfl_done !== (beat == LW - 1)) begin bad++; $display("FAIL rfl_done beat=%0d got=%b exp=%b", beat, rfl_done, beat == LW - 1); end
        ref_mem[12'h040 + beat] = rfl_data;
        beat++;
      end else begin
        total++; if (data_cen !== 1'b1 || rfl_done !== 1'b0) begin bad++; $display("FAIL rfl_gap c=%0d cen=%b done=%b exp 1 0", c, data_cen, rfl_done); end
      end
    end
    @(negedge clk); rfl_data_vld = 0; #1;
    total++; if (ld_gnt !== 1'b1 || data_idx !== 12'h040) begin bad++; $display("FAIL rfl_then_ld gnt=%b idx=%h exp 1 040", ld_gnt, data_idx); end
    @(negedge clk); ld_req = 0; #1;
    total++; if (ld_data_vld !== 1'b1 || ld_data !== ref_mem[12'h040]) begin bad++; $display("FAIL rfl_readback vld=%b got=%h exp=%h", ld_data_vld, ld_data, ref_mem[12'h040]); end
  endtask

  task automatic test_wb(input logic [IW-1:0] widx);
    logic [IW-1:0] b;
    b = {widx[IW-1:2], 2'b00};
    @(negedge clk); wb_req = 1; wb_idx = widx; #1;
    total++; if ({wb_gnt, data_cen, data_gwen} !== 3'b101 || data_idx !== b) begin bad++; $display("FAIL wb_gnt gnt/cen/gwen=%b idx=%h exp 101 %h", {wb_gnt, data_cen, data_gwen}, data_idx, b); end
    for (int k = 1; k <= LW; k++) begin
      @(negedge clk); wb_req = 0; ld_req = (k >= 2); ld_idx = b; #1;
      if (k < LW) begin
        total++; if ({data_cen, data_gwen} !== 2'b01 || data_idx !== IW'(b + k) || ld_gnt !== 1'b0) begin bad++; $display("FAIL wb_read%0d cen/gwen=%b idx=%h ld_gnt=%b exp 01 %h 0", k, {data_cen, data_gwen}, data_idx, ld_gnt, b + k); end
      end else begin
        total++; if (ld_gnt !== 1'b1) begin bad++; $display("FAIL wb_idle_after ld_gnt got=%b exp=1", ld_gnt); end
      end
      total++;
      if (wb_data_vld !== 1'b1 || wb_data !== ref_mem[IW'(b + k - 1)] || wb_done !== (k == LW) || ld_data_vld !== 1'b0) begin
        bad++; $display("FAIL wb_data%0d vld=%b data=%h done=%b ldvld=%b exp 1 %h %b 0", k, wb_data_vld, wb_data, wb_done, ld_data_vld, ref_mem[IW'(b + k - 1)], k == LW);
      end
    end
    @(negedge clk); ld_req = 0; #1;
    total++; if (wb_data_vld !== 1'b0 || ld_data_vld !== 1'b1 || ld_data !== ref_mem[b]) begin bad++; $display("FAIL wb_then_ld wbvld=%b ldvld=%b data=%h exp 0 1 %h", wb_data_vld, ld_data_vld, ld_data, ref_mem[b]); end
  endtask

  task automatic test_starve();
    int starve = 0;
    logic exp_ld;
    logic pend = 0;
    logic [IW-1:0] pend_idx = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      st_req = 1; ld_req = 1; st_idx = IW'($urandom); ld_idx = IW'($urandom);
      st_be = 4'($urandom); st_data = $urandom; #1;
      exp_ld = (starve == SL);
      total++; if (ld_gnt !== exp_ld || st_gnt !== !exp_ld) begin bad++; $display("FAIL starve c=%0d ld_gnt=%b st_gnt=%b exp %b %b", c, ld_gnt, st_gnt, exp_ld, !exp_ld); end
      if (pend) begin
        total++; if (ld_data_vld !== 1'b1 || ld_data !== ref_mem[pend_idx]) begin bad++; $display("FAIL starve_ld_data vld=%b got=%h exp=%h", ld_data_vld, ld_data, ref_mem[pend_idx]); end
      end
      pend = exp_ld; pend_idx = ld_idx;
      if (exp_ld) starve = 0;
      else begin
        ref_mem[st_idx] = merge_store(ref_mem[st_idx], st_data, st_be);
        starve = (starve < SL) ? starve + 1 : SL;
      end
    end
    @(negedge clk); clear_inputs(); #1;
    if (pend) begin
      total++; if (ld_data_vld !== 1'b1 || ld_data !== ref_mem[pend_idx]) begin bad++; $display("FAIL starve_ld_tail vld=%b got=%h exp=%h", ld_data_vld, ld_data, ref_mem[pend_idx]); end
    end
  endtask

  task automatic test_reset_mid_rfl();
    logic [IW-1:0] b;
    b = {IW'($urandom) >> 2, 2'b00};
    @(negedge clk); rfl_req = 1; rfl_idx = b | IW'($urandom_range(0, 3)); #1;
    total++; if (rfl_gnt !== 1'b1) begin bad++; $display("FAIL rst_rfl_gnt got=%b exp=1", rfl_gnt); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); rfl_req = 0; rfl_data_vld = 1; rfl_data = $urandom;
      ref_mem[IW'(b + k)] = rfl_data;
    end
    @(negedge clk); cpurst = 1; rfl_data = $urandom; #1;
    total++; if (data_cen !== 1'b1 || rfl_done !== 1'b0) begin bad++; $display("FAIL rst_mid cen=%b done=%b exp 1 0", data_cen, rfl_done); end
    @(negedge clk); cpurst = 0; #1;
    total++; if ({data_cen, rfl_done, rfl_gnt, ld_data_vld, wb_data_vld} !== 5'b10000) begin bad++; $display("FAIL rst_after cen/done/gnt/vlds=%b exp 10000", {data_cen, rfl_done, rfl_gnt, ld_data_vld, wb_data_vld}); end
    @(negedge clk); rfl_data_vld = 0; rfl_req = 1; rfl_idx = b; #1;
    total++; if (rfl_gnt !== 1'b1) begin bad++; $display("FAIL rst_fresh_rfl_gnt got=%b exp=1", rfl_gnt); end
    for (int k = 0; k < LW; k++) begin
      @(negedge clk); rfl_req = 0; rfl_data_vld = 1; rfl_data = $urandom; #1;
      total++; if (rfl_done !== (k == LW - 1) || data_idx !== IW'(b + k)) begin bad++; $display("FAIL rst_fresh_beat%0d done=%b idx=%h exp %b %h", k, rfl_done, data_idx, k == LW - 1, b + k); end
      ref_mem[IW'(b + k)] = rfl_data;
    end
    @(negedge clk); clear_inputs();
    test_wb(b);
  endtask

  task automatic test_random();
    logic vld;
    logic [31:0] d;
    logic [IW-1:0] ia, b;
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          @(negedge clk); st_req = 1; st_idx = IW'($urandom); st_be = 4'($urandom); st_data = $urandom; #1;
          total++; if (st_gnt !== 1'b1 || data_cen !== (st_be == 4'b0)) begin bad++; $display("FAIL rnd_st gnt=%b cen=%b be=%b", st_gnt, data_cen, st_be); end
          ref_mem[st_idx] = merge_store(ref_mem[st_idx], st_data, st_be);
          @(negedge clk); clear_inputs();
        end
        1: begin
          ia = IW'($urandom);
          do_load(ia, vld, d);
          total++; if (vld !== 1'b1 || d !== ref_mem[ia]) begin bad++; $display("FAIL rnd_ld idx=%h vld=%b got=%h exp=%h", ia, vld, d, ref_mem[ia]); end
        end
        2: begin
          b = {IW'($urandom) >> 2, 2'b00};
          @(negedge clk); rfl_req = 1; rfl_idx = b | IW'($urandom_range(0, 3));
          for (int k = 0; k < LW; k++) begin
            @(negedge clk); rfl_req = 0; rfl_data_vld = 0;
            while ($urandom_range(0, 2) == 0) @(negedge clk);
            rfl_data_vld = 1; rfl_data = $urandom; #1;
            total++; if (rfl_done !== (k == LW - 1)) begin bad++; $display("FAIL rnd_rfl_done beat=%0d got=%b", k, rfl_done); end
            ref_mem[IW'(b + k)] = rfl_data;
          end
          @(negedge clk); clear_inputs();
        end
        default: test_wb(IW'($urandom));
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = seed_word(i);
    cpurst = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    test_reset();
    test_load();
    test_store();
    test_refill();
    @(negedge clk); clear_inputs();
    test_wb(12'h080);
    @(negedge clk); clear_inputs();
    test_starve();
    test_reset_mid_rfl();
    @(negedge clk); clear_inputs();
    test_random();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pa_dcache_data_ctrl.md
Name: pa_dcache_data_ctrl

Overview:
- Sequences and shares the single-port dcache data SRAM wrapper (128x32..4096x32, active-low CEN/GWEN/WEN, 1-cycle read latency) among four requesters.
- Requesters: linefill refill writes, victim write-back burst reads, store word writes and load word reads.
- Drives the SRAM wrapper's clk_en, cen, gwen, wen, din and idx, and routes read data back to the owning requester.
- Sits in the LSU between the dcache control FSMs and the data array.

Parameters:
IDX_WIDTH, 12, data array word-index width
LINE_WORDS, 4, words per cache line (power of 2; burst length)
STARVE_LIMIT, 4, consecutive load losses to stores before load is promoted

Ports:
forever_cpuclk  in  1  clock
cpurst  in  1  synchronous active-high reset
ld_req  in  1  load word read request
ld_idx  in  IDX_WIDTH  load word index
ld_gnt  out  1  load accepted; SRAM read this cycle
ld_data_vld  out  1  load data valid (gnt+1)
ld_data  out  32  load read data
st_req  in  1  store request
st_idx  in  IDX_WIDTH  store word index
st_be  in  4  store byte enables
st_data  in  32  store data
st_gnt  out  1  store accepted; written this cycle
rfl_req  in  1  refill burst request
rfl_idx  in  IDX_WIDTH  line base (low log2(LINE_WORDS) bits ignored)
rfl_data_vld  in  1  refill beat valid
rfl_data  in  32  refill beat data
rfl_gnt  out  1  refill burst accepted (pulse)
rfl_done  out  1  last refill beat written (pulse)
wb_req  in  1  victim read burst request
wb_idx  in  IDX_WIDTH  victim line base
wb_gnt  out  1  victim burst accepted (pulse)
wb_data_vld  out  1  victim word valid
wb_data  out  32  victim word
wb_done  out  1  with last wb_data_vld
data_dout  in  32  SRAM Q
data_clk_en  out  1  SRAM clock-gate local enable
data_cen  out  1  SRAM chip enable, active-low
data_gwen  out  1  SRAM global write enable, active-low
data_wen  out  32  SRAM bit write enables, active-low
data_din  out  32  SRAM write data
data_idx  out  IDX_WIDTH  SRAM address

Behaviour:
- Reset:
  - State IDLE; counters 0.
  - data_cen=1, data_gwen=1, data_wen=all 1, data_clk_en=0.
  - All gnt/vld/done=0.
  - While cpurst=1, no grants are issued.
  - Reset mid-burst aborts the burst with no done pulse and no pending vld.
- SRAM controls are combinational from state and arbitration; data_clk_en=~data_cen.
- FSM IDLE:
  - Fixed priority rfl > wb > st > ld.
  - Exception: when the starvation counter equals STARVE_LIMIT, ld outranks st (still below rfl/wb).
  - One grant per cycle.
- rfl grant: rfl_gnt pulse, no SRAM access that cycle, go to RFL with base latched and beat counter=0.
- RFL:
  - Each rfl_data_vld writes rfl_data to {base, cnt}: cen=0, gwen=0, wen=0. cnt increments.
  - On beat LINE_WORDS-1: rfl_done that cycle, return to IDLE.
  - Cycles without vld perform no access. Other requesters are stalled.
- wb grant:
  - wb_gnt pulse; read word 0 the same cycle (cen=0, gwen=1).
  - Go to WB and read words 1..LINE_WORDS-1 on consecutive cycles, then return to IDLE.
  - wb_data_vld=1 one cycle after each read; wb_data=data_dout.
  - wb_done accompanies the last vld. The cycle after the last read is already IDLE and may grant.
- st grant:
  - cen=0, gwen=0, din=st_data.
  - wen byte lane k = ~st_be[k] replicated over 8 bits.
  - st_be=0: still granted, but cen stays 1 (no access).
- ld grant: cen=0, gwen=1. Next cycle ld_data_vld=1 with ld_data=data_dout.
- A 1-bit read-owner flag registered at read issue steers data_dout to the ld or wb outputs. Out-of-range rfl/wb inputs outside their states are ignored.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when ld_req & st_gnt.
  - Clears on ld_gnt or when ld_req=0.

Decomposition:
- Shared LSU package/define file: FSM state encoding (IDLE/RFL/WB), LINE_WORDS, IDX_WIDTH, and the active-low SRAM idle constants.
- One sub-module, pa_dcache_data_arb: combinational priority select plus the starvation counter. The parent holds the FSM, burst counter, address/owner registers and output muxing.

Test Plan:
- Reset, then ld_req with ld_idx=0x010 -> ld_gnt same cycle, cen=0/gwen=1/idx=0x010; next cycle ld_data_vld=1, ld_data=data_dout.
- st_req with st_idx=0x020, st_be=4'b0101, data=0xAABBCCDD -> st_gnt, gwen=0, wen=0xFF00FF00, din=0xAABBCCDD.
- rfl_req with rfl_idx=0x043, then 4 beats with gaps -> rfl_gnt; writes to 0x040..0x043 only on vld cycles; rfl_done on 4th beat. A ld_req held throughout is granted only after return to IDLE.
- wb_req with wb_idx=0x080 -> reads 0x080..0x083 on 4 consecutive cycles; wb_data_vld cycles 2-5; wb_done with the 4th.
- st_req and ld_req held together for 6 cycles -> st granted 4 cycles, ld granted in cycle 5, st in cycle 6.
- cpurst pulsed during RFL after 2 beats -> next cycle IDLE, cen=1, no rfl_done; a fresh rfl_req is granted afterwards.
